// File: rtl/mult_chk_pkg.sv
// Shared types and the reference model for the multiplier self-checker.
// The model is sized for operands up to MAX_W bits; callers zero-extend narrower operands.
package mult_chk_pkg;

  localparam int MAX_W = 32;
  localparam int PW    = 2 * MAX_W;

  localparam int MM_RESULT = 0;
  localparam int MM_PARITY = 1;
  localparam int MM_ERR    = 2;

  typedef struct packed {
    logic [PW-1:0] exp_result;
    logic          exp_parity;
    logic          exp_err;
  } pred_t;

  // Operands are zero-extended to MAX_W, so their XOR parity is unchanged; the
  // sign bit sits at position w-1 and is replicated upward only in signed mode.
  function automatic pred_t predict(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             pa,
    input logic             pb,
    input logic             signed_mode,
    input int               w
  );
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    logic [PW-1:0] mask;
    logic [PW-1:0] prod;
    logic          sa;
    logic          sb;
    logic          ok;
    pred_t         p;
    sa = 1'b0;
    sb = 1'b0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j == w - 1) begin
        sa = a[j];
        sb = b[j];
      end
    end
    ea = {{MAX_W{1'b0}}, a};
    eb = {{MAX_W{1'b0}}, b};
    for (int i = 0; i < PW; i++) begin
      mask[i] = (i < 2 * w);
      if (signed_mode && (i >= w)) begin
        ea[i] = sa;
        eb[i] = sb;
      end
    end
    ok   = (pa == ^a) && (pb == ^b);
    prod = ok ? ((ea * eb) & mask) : '0;
    p.exp_result = prod;
    p.exp_parity = ^prod;
    p.exp_err    = !ok;
    return p;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Small synchronous FIFO for the checker scoreboard.
// No overflow/underflow protection: the parent gates push and pop.
module sb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/mult_parity_checker.sv
// Snooping self-checker for the parity-protected multiplier: predicts each response on
// the request edge, queues it, and scores the DUT answers in order.
module mult_parity_checker
  import mult_chk_pkg::*;
#(
  parameter int W           = 16,
  parameter int DEPTH       = 8,
  parameter int MAX_LATENCY = 64,
  parameter int SIGNED      = 1,
  parameter int CNT_W       = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_req,
  input  logic [W-1:0]               i_arg_a,
  input  logic [W-1:0]               i_arg_b,
  input  logic                       i_arg_a_parity,
  input  logic                       i_arg_b_parity,
  input  logic                       i_result_rdy,
  input  logic [2*W-1:0]             i_result,
  input  logic                       i_result_parity,
  input  logic                       i_arg_parity_error,
  output logic [CNT_W-1:0]           o_pass_cnt,
  output logic [CNT_W-1:0]           o_fail_cnt,
  output logic [2:0]                 o_mismatch_mask,
  output logic [$clog2(DEPTH+1)-1:0] o_queue_level,
  output logic                       o_err_overflow,
  output logic                       o_err_underflow,
  output logic                       o_err_timeout,
  output logic                       o_test_failed
);

  localparam int AGE_W = $clog2(MAX_LATENCY + 1);

  logic             r_req_prev;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [2:0]       r_mismatch_mask;
  logic             r_err_overflow;
  logic             r_err_underflow;
  logic             r_err_timeout;
  logic             r_test_failed;
  logic [AGE_W-1:0] r_age;

  pred_t            w_pred;
  pred_t            w_head;
  logic             w_capture;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_overflow;
  logic             w_underflow;
  logic             w_timeout;
  logic             w_fail;
  logic [2:0]       w_mismatch;

  assign w_capture = i_req && !r_req_prev;
  assign w_pred    = predict(MAX_W'(i_arg_a), MAX_W'(i_arg_b), i_arg_a_parity,
                             i_arg_b_parity, (SIGNED != 0), W);

  assign w_pop       = i_result_rdy && !w_empty;
  assign w_push      = w_capture && (!w_full || w_pop);
  assign w_overflow  = w_capture && w_full && !w_pop;
  assign w_underflow = i_result_rdy && w_empty;
  assign w_timeout   = (r_age == AGE_W'(MAX_LATENCY));

  sb_fifo #(
    .WIDTH ($bits(pred_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pred),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_queue_level)
  );

  // Case inequality so that X/Z on any DUT field is scored as a mismatch.
  always_comb begin
    w_mismatch            = 3'b000;
    w_mismatch[MM_RESULT] = (w_head.exp_result !== PW'(i_result));
    w_mismatch[MM_PARITY] = (w_head.exp_parity !== i_result_parity);
    w_mismatch[MM_ERR]    = (w_head.exp_err !== i_arg_parity_error);
  end

  assign w_fail = w_pop && (w_mismatch != 3'b000);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_req_prev      <= 1'b0;
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
      r_mismatch_mask <= 3'b000;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_test_failed   <= 1'b0;
      r_age           <= '0;
    end else begin
      r_req_prev <= i_req;
      if (w_pop) begin
        r_mismatch_mask <= w_mismatch;
        if (w_fail) begin
          if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
        end else begin
          if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
        end
      end
      if (w_overflow)  r_err_overflow  <= 1'b1;
      if (w_underflow) r_err_underflow <= 1'b1;
      if (w_timeout)   r_err_timeout   <= 1'b1;
      r_test_failed <= r_test_failed | w_fail | w_overflow | w_underflow | w_timeout;
      // Age tracks how long the current head has waited; it saturates at the limit.
      if (w_pop || w_empty) begin
        r_age <= '0;
      end else if (!w_timeout) begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  assign o_pass_cnt      = r_pass_cnt;
  assign o_fail_cnt      = r_fail_cnt;
  assign o_mismatch_mask = r_mismatch_mask;
  assign o_err_overflow  = r_err_overflow;
  assign o_err_underflow = r_err_underflow;
  assign o_err_timeout   = r_err_timeout;
  assign o_test_failed   = r_test_failed;

endmodule
